// File: rtl/test_sig_monitor.sv
// Snoops RAM writes for begin/end/flag words, then streams the signature region out.
// Optional SIG_CHECKSUM_EN adds a running sum of accepted signature words on sig_sum.
module test_sig_monitor #(
  parameter int unsigned FLAG_WADDR  = 4,
  parameter int unsigned BEGIN_WADDR = 2,
  parameter int unsigned END_WADDR   = 3,
  parameter int unsigned TIMEOUT_CYC = 25000,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic [AW-3:0] wr_waddr,
  input  logic [DW-1:0] wr_data,
  output logic          rd_en,
  output logic [AW-3:0] rd_waddr,
  input  logic [DW-1:0] rd_data,
  output logic          sig_valid,
  output logic [DW-1:0] sig_data,
  input  logic          sig_ready,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   sig_cnt,
  output logic [DW-1:0] sig_sum
);

  localparam int unsigned PW = AW - 2;

  localparam logic [2:0] StMonitor = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StSend    = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
  localparam logic [2:0] StTout    = 3'd5;

  localparam logic [PW-1:0] FlagW    = PW'(FLAG_WADDR);
  localparam logic [PW-1:0] BeginW   = PW'(BEGIN_WADDR);
  localparam logic [PW-1:0] EndW     = PW'(END_WADDR);
  localparam logic [23:0]   WdogLast = 24'(TIMEOUT_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] end_q, end_d;
  logic [23:0]   wdog_q, wdog_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          flag_hit;
  logic          handshake;
  logic [PW:0]   ptr_next;

  assign flag_hit  = wr_en && (wr_waddr == FlagW) && (wr_data == DW'(1));
  assign handshake = (state_q == StSend) && sig_ready;
  // One extra bit so the end-bound compare can never see a wrapped pointer.
  assign ptr_next  = {1'b0, ptr_q} + (PW+1)'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    wdog_d  = wdog_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      StMonitor: begin
        wdog_d = wdog_q + 24'd1;
        if (wr_en && (wr_waddr == BeginW)) ptr_d = wr_data[AW-1:2];
        if (wr_en && (wr_waddr == EndW))   end_d = wr_data[AW-1:2];
        // A flag write in the expiry cycle still starts the dump.
        if (flag_hit) begin
          state_d = (ptr_q >= end_q) ? StDone : StFetch;
        end else if (wdog_q == WdogLast) begin
          state_d = StTout;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        data_d  = rd_data;
        state_d = StSend;
      end
      StSend: begin
        if (sig_ready) begin
          ptr_d   = ptr_next[PW-1:0];
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = (ptr_next < {1'b0, end_q}) ? StFetch : StDone;
        end
      end
      StDone:  state_d = StDone;
      StTout:  state_d = StTout;
      default: state_d = StMonitor;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StMonitor;
      ptr_q   <= '0;
      end_q   <= '0;
      wdog_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      wdog_q  <= wdog_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SIG_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (handshake) sum_d = sum_q + data_q;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sum_q <= '0;
    else            sum_q <= sum_d;
  end

  assign sig_sum = sum_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign sig_sum          = '0;
`endif

  assign rd_en     = (state_q == StFetch);
  assign rd_waddr  = ptr_q;
  assign sig_valid = (state_q == StSend);
  assign sig_data  = data_q;
  assign done      = (state_q == StDone);
  assign timeout   = (state_q == StTout);
  assign sig_cnt   = cnt_q;

endmodule

// File: tb/tb_test_sig_monitor.sv
// Directed bench for test_sig_monitor: scoreboard of expected stream words and read addresses.
module tb_test_sig_monitor;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [29:0] wr_waddr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en;
  logic [29:0] rd_waddr;
  logic [31:0] rd_data = '0;
  logic        sig_valid;
  logic [31:0] sig_data;
  logic        sig_ready = 1'b0;
  logic        done;
  logic        timeout;
  logic [15:0] sig_cnt;
  logic [31:0] sig_sum;

  int          n_assert = 0;
  int          n_fail = 0;
  int          n;
  logic [31:0] exp_sum = '0;
  logic [31:0] sb[$];
  logic [29:0] addr_q[$];
  logic [31:0] mem[logic [29:0]];

  test_sig_monitor #(.TIMEOUT_CYC(100)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .wr_waddr  (wr_waddr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_waddr  (rd_waddr),
    .rd_data   (rd_data),
    .sig_valid (sig_valid),
    .sig_data  (sig_data),
    .sig_ready (sig_ready),
    .done      (done),
    .timeout   (timeout),
    .sig_cnt   (sig_cnt),
    .sig_sum   (sig_sum)
  );

  always #5 clk = ~clk;

  // Memory model: read data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem.exists(rd_waddr) ? mem[rd_waddr] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream and read-address monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sys_rst_n && sig_valid) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sig_extra: observed sig_valid=1 with data 0x%0h expected no word", sig_data);
      end
      if (sb.size() != 0) begin
        chk("sig_data", sig_data, sb[0]);
        if (sig_ready) begin
          exp_sum = exp_sum + sb[0];
          void'(sb.pop_front());
        end
      end
    end
    if (sys_rst_n && rd_en) begin
      n_assert++;
      assert (addr_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rd_extra: observed rd_en=1 addr 0x%0h expected no read", rd_waddr);
      end
      if (addr_q.size() != 0) begin
        chk("rd_waddr", {2'b00, rd_waddr}, {2'b00, addr_q[0]});
        void'(addr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({tag, "_rd_waddr"}, {2'b00, rd_waddr}, 32'd0);
    chk({tag, "_sig_valid"}, {31'd0, sig_valid}, 32'd0);
    chk({tag, "_sig_data"}, sig_data, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_sig_cnt"}, {16'd0, sig_cnt}, 32'd0);
    chk({tag, "_sig_sum"}, sig_sum, 32'd0);
  endtask

  task automatic reset_dut(input string tag);
    sys_rst_n = 1'b0;
    wr_en     = 1'b0;
    sig_ready = 1'b0;
    #1;
    check_zero(tag);
    sb.delete();
    addr_q.delete();
    exp_sum = '0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    wr_en    = 1'b1;
    wr_waddr = a;
    wr_data  = d;
    tick();
    wr_en    = 1'b0;
  endtask

  // Queue the expected words and read addresses, then write the end-of-test flag.
  task automatic start_dump(input logic [31:0] b, input logic [31:0] e);
    for (int a = int'(b >> 2); a < int'(e >> 2); a++) begin
      sb.push_back(mem[30'(a)]);
      addr_q.push_back(30'(a));
    end
    wr(30'd4, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [31:0] exp_chk(input logic [31:0] s);
`ifdef SIG_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  initial begin
    #2;
    mem[30'h40] = 32'hAAAA_0001;
    mem[30'h41] = 32'hBBBB_0002;
    mem[30'h42] = 32'hCCCC_0003;
    mem[30'h43] = 32'hDDDD_0004;
    mem[30'hC0] = 32'h1234_5678;
    mem[30'hC1] = 32'h9ABC_DEF0;
    mem[30'h50] = 32'h0000_0001;
    mem[30'h51] = 32'h0000_0002;
    mem[30'h52] = 32'hFFFF_FFFF;

    // Four-word dump with ready held high.
    reset_dut("rst1");
    wr(30'd2, 32'h100);
    wr(30'd3, 32'h110);
    sig_ready = 1'b1;
    start_dump(32'h100, 32'h110);
    chk("t1_fetch_rd_en", {31'd0, rd_en}, 32'd1);
    wait_done(n);
    chk("t1_cycles", n, 32'd12);
    chk("t1_cnt", {16'd0, sig_cnt}, 32'd4);
    chk("t1_sb_left", sb.size(), 32'd0);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    chk("t1_rd_en_done", {31'd0, rd_en}, 32'd0);
    chk("t1_sum", sig_sum, exp_chk(exp_sum));

    // Stall on word B for five cycles; snooped writes during the dump are ignored.
    reset_dut("rst2");
    wr(30'd2, 32'h100);
    wr(30'd3, 32'h110);
    sig_ready = 1'b1;
    start_dump(32'h100, 32'h110);
    repeat (5) tick();
    sig_ready = 1'b0;
    chk("t2_valid_b", {31'd0, sig_valid}, 32'd1);
    chk("t2_data_b", sig_data, 32'hBBBB_0002);
    wr(30'd3, 32'h104);
    wr(30'd4, 32'd1);
    repeat (3) tick();
    chk("t2_data_b_held", sig_data, 32'hBBBB_0002);
    sig_ready = 1'b1;
    wait_done(n);
    chk("t2_cycles", n, 32'd7);
    chk("t2_cnt", {16'd0, sig_cnt}, 32'd4);
    chk("t2_sb_left", sb.size(), 32'd0);

    // Empty region goes straight to DONE.
    reset_dut("rst3");
    wr(30'd2, 32'h200);
    wr(30'd3, 32'h200);
    start_dump(32'h200, 32'h200);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_rd_en", {31'd0, rd_en}, 32'd0);
    chk("t3_cnt", {16'd0, sig_cnt}, 32'd0);

    // Watchdog expiry after 100 MONITOR cycles.
    reset_dut("rst4");
    repeat (99) tick();
    chk("t4_timeout_99", {31'd0, timeout}, 32'd0);
    tick();
    chk("t4_timeout_100", {31'd0, timeout}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);
    repeat (3) tick();
    chk("t4_timeout_hold", {31'd0, timeout}, 32'd1);

    // Flag write in the expiry cycle wins.
    reset_dut("rst5");
    repeat (99) tick();
    chk("t5_timeout_99", {31'd0, timeout}, 32'd0);
    start_dump(32'h0, 32'h0);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_timeout", {31'd0, timeout}, 32'd0);
    repeat (3) tick();
    chk("t5_timeout_hold", {31'd0, timeout}, 32'd0);

    // Flag value 2 ignored; reset during SEND aborts.
    reset_dut("rst6");
    wr(30'd2, 32'h300);
    wr(30'd3, 32'h308);
    wr(30'd4, 32'd2);
    repeat (3) tick();
    chk("t6_ign_rd_en", {31'd0, rd_en}, 32'd0);
    chk("t6_ign_valid", {31'd0, sig_valid}, 32'd0);
    chk("t6_ign_done", {31'd0, done}, 32'd0);
    start_dump(32'h300, 32'h308);
    chk("t6_rd_en", {31'd0, rd_en}, 32'd1);
    chk("t6_rd_waddr", {2'b00, rd_waddr}, 32'hC0);
    tick();
    tick();
    chk("t6_send", {31'd0, sig_valid}, 32'd1);
    reset_dut("t6_midrst");
    repeat (3) tick();
    chk("t6_after_valid", {31'd0, sig_valid}, 32'd0);
    chk("t6_after_rd_en", {31'd0, rd_en}, 32'd0);

    // Checksum wraps modulo 2^32.
    reset_dut("rst7");
    wr(30'd2, 32'h140);
    wr(30'd3, 32'h14C);
    sig_ready = 1'b1;
    start_dump(32'h140, 32'h14C);
    wait_done(n);
    chk("t7_cycles", n, 32'd9);
    chk("t7_cnt", {16'd0, sig_cnt}, 32'd3);
    chk("t7_sum", sig_sum, exp_chk(32'd2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/test_sig_monitor.md
TEST_SIG_MONITOR -- requirements
Module: test_sig_monitor

Interface
REQ-001 SHALL provide parameter FLAG_WADDR, default 4, word address of end-of-test flag.
REQ-002 SHALL provide parameter BEGIN_WADDR, default 2, word address holding signature begin byte address.
REQ-003 SHALL provide parameter END_WADDR, default 3, word address holding signature end byte address.
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 25000, watchdog limit in clk cycles (1..2^24-1).
REQ-005 SHALL provide parameter AW, default 32, address width; parameter DW, default 32, data width.
REQ-006 SHALL have ports: clk  in  1  single clock; sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: wr_en  in  1  snooped RAM write strobe; wr_waddr  in  AW-2  snooped word address; wr_data  in  DW  snooped write data.
REQ-008 SHALL have ports: rd_en  out  1  memory read request; rd_waddr  out  AW-2  read word address; rd_data  in  DW  read data, valid exactly 1 cycle after rd_en.
REQ-009 SHALL have ports: sig_valid  out  1; sig_data  out  DW; sig_ready  in  1  signature word stream handshake.
REQ-010 SHALL have ports: done  out  1  dump complete; timeout  out  1  watchdog expired; sig_cnt  out  16  words emitted; sig_sum  out  DW  running checksum.

Function
REQ-011 SHALL implement states MONITOR, FETCH, WAIT, SEND, DONE, TOUT.
REQ-012 In MONITOR, wr_en with wr_waddr==BEGIN_WADDR SHALL capture wr_data[AW-1:2] into begin pointer; likewise END_WADDR into end pointer; bits [1:0] ignored.
REQ-013 In MONITOR, wr_en with wr_waddr==FLAG_WADDR and wr_data==1 SHALL transition next cycle to FETCH, or to DONE when begin pointer >= end pointer (zero words).
REQ-014 Flag write with any value other than 1 SHALL be ignored.
REQ-015 FETCH SHALL assert rd_en for exactly one cycle with rd_waddr = current pointer, then go to WAIT.
REQ-016 WAIT SHALL register rd_data into sig_data and go to SEND with sig_valid=1.
REQ-017 In SEND, sig_valid and sig_data SHALL hold stable until sig_ready=1; on handshake pointer +1 word, sig_cnt +1, then FETCH if pointer+1 < end, else DONE.
REQ-018 Throughput SHALL be one word per 3 cycles with sig_ready held high.
REQ-019 Pointer comparison SHALL be unsigned on AW-2 bits; pointer SHALL NOT wrap (end is exclusive bound).
REQ-020 sig_cnt SHALL saturate at 16'hFFFF.
REQ-021 Watchdog counter SHALL increment every cycle in MONITOR only; at TIMEOUT_CYC it SHALL go to TOUT.
REQ-022 Flag write and watchdog expiry in the same cycle: flag SHALL win.
REQ-023 DONE and TOUT SHALL be terminal until reset; done=1 only in DONE, timeout=1 only in TOUT; both never 1 together.
REQ-024 Snooped writes outside MONITOR SHALL be ignored.

Reset
REQ-025 sys_rst_n low SHALL asynchronously force MONITOR, pointers 0, watchdog 0, rd_en 0, sig_valid 0, sig_data 0, done 0, timeout 0, sig_cnt 0, sig_sum 0.
REQ-026 Reset asserted mid-dump SHALL abort the transfer; no partial handshake state retained.

Configuration
REQ-027 With SIG_CHECKSUM_EN defined, sig_sum SHALL equal the modulo-2^DW sum of all sig_data accepted by handshake, updated the cycle after each handshake.
REQ-028 Without SIG_CHECKSUM_EN, sig_sum SHALL be constant 0 and no adder SHALL be instantiated.

Verification
REQ-029 Write BEGIN=0x100, END=0x110, FLAG=1, memory 0x40..0x43 = A,B,C,D, sig_ready=1 -> four words A,B,C,D on stream, sig_cnt=4, done=1, 12 cycles from FETCH entry to DONE.
REQ-030 Same as REQ-029 with sig_ready low 5 cycles on word B -> sig_data=B stable for those cycles, order and count unchanged.
REQ-031 BEGIN=0x200, END=0x200, FLAG=1 -> no rd_en, done=1 next cycle, sig_cnt=0.
REQ-032 No flag write, TIMEOUT_CYC=100 -> timeout=1 after 100 cycles in MONITOR, done stays 0; flag write at cycle 100 instead -> done path, timeout 0.
REQ-033 FLAG=2 then FLAG=1 -> first ignored, dump starts only after second; reset asserted during SEND -> all outputs zero immediately.
REQ-034 With SIG_CHECKSUM_EN, words 1,2,0xFFFFFFFF -> sig_sum=2; without it sig_sum=0.
